// File: rtl/mul_add_seq.sv
// Shift-add multiply-accumulate: p = q*b + r (unsigned), one operand set at a time.
// Latency: accept on edge k, out_valid first high after edge k+DIV_W+1.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
module mul_add_seq #(
    parameter int DIV_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DIV_W-1:0]     q,
    input  logic [DIV_W-1:0]     b,
    input  logic [DIV_W-1:0]     r,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*DIV_W-1:0]   p,
    output logic                 bad_rem
);

    localparam int CNT_W = (DIV_W > 1) ? $clog2(DIV_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q,     state_d;
    logic [2*DIV_W-1:0]     acc_q,       acc_d;
    logic [2*DIV_W-1:0]     mcand_q,     mcand_d;
    logic [DIV_W-1:0]       mplier_q,    mplier_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    logic                   bad_rem_q,   bad_rem_d;
    logic [2*DIV_W-1:0]     p_q,         p_d;
    logic                   out_valid_q, out_valid_d;

    // State and datapath registers; synchronous reset discards any partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            bad_rem_q   <= 1'b0;
            p_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            bad_rem_q   <= bad_rem_d;
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state: latch operands in IDLE, one shift-add step per MUL cycle,
    // present the registered result in DONE and hold it until taken.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        bad_rem_d   = bad_rem_q;
        p_d         = p_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d     = {{DIV_W{1'b0}}, r};
                    mcand_d   = {{DIV_W{1'b0}}, b};
                    mplier_d  = q;
                    cnt_d     = '0;
                    bad_rem_d = (r >= b);
                    state_d   = MUL;
                end
            end
            MUL: begin
                // Fixed DIV_W iterations: no early exit when the multiplier empties.
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // First DONE cycle registers the result; the handshake happens after that.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    p_d         = acc_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign p         = p_q;
    assign bad_rem   = bad_rem_q;

endmodule

// File: tb/tb_mul_add_seq.sv
// Bench for mul_add_seq: directed corners plus randomized triples against q*b+r.
// Checks latency, handshake, backpressure stability, reset abort and ignored inputs.
// All checks funnel through check_val.
module tb_mul_add_seq;

    localparam int W = 16;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    q;
    logic [W-1:0]    b;
    logic [W-1:0]    r;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  p;
    logic            bad_rem;

    int total = 0;
    int bad   = 0;

    mul_add_seq #(.DIV_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .b         (b),
        .r         (r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .bad_rem   (bad_rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: plain arithmetic from the operand rules.
    function automatic logic [2*W-1:0] ref_p(input logic [W-1:0] tq, tb, tr);
        logic [63:0] full;
        full = 64'(tq) * 64'(tb) + 64'(tr);
        return full[2*W-1:0];
    endfunction

    // One full transaction. hold: cycles of out_ready=0 once out_valid is up
    // (0 means out_ready already high when the result appears). poke: drive
    // garbage operands with in_valid high while the block is busy.
    task automatic run_txn(input logic [W-1:0] tq, tb, tr, input int hold, input bit poke);
        logic [2*W-1:0] exp_p;
        logic           exp_bad;
        int             lat;
        bit             seen;
        bit             idle_ok;
        exp_p   = ref_p(tq, tb, tr);
        exp_bad = (tr >= tb);

        idle_ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin
                idle_ok = 1'b1;
                break;
            end
        end
        check_val("wait_idle", 64'(idle_ok), 64'd1);

        in_valid  = 1'b1;
        q         = tq;
        b         = tb;
        r         = tr;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        if (poke) begin
            q = W'($urandom);
            b = W'($urandom);
            r = W'($urandom);
        end else begin
            in_valid = 1'b0;
        end

        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (poke && (lat % 3 == 0)) begin
                q = W'($urandom);
                r = W'($urandom);
            end
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        check_val("out_valid_seen", 64'(seen), 64'd1);
        check_val("latency", 64'(lat), 64'(W + 1));
        check_val("p", 64'(p), 64'(exp_p));
        check_val("bad_rem", 64'(bad_rem), 64'(exp_bad));
        check_val("in_ready_done", 64'(in_ready), 64'd0);

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val("hold_valid", 64'(out_valid), 64'd1);
            check_val("hold_p", 64'(p), 64'(exp_p));
            check_val("hold_bad", 64'(bad_rem), 64'(exp_bad));
            check_val("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val("post_valid", 64'(out_valid), 64'd0);
        check_val("post_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        bit never;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        q         = '0;
        b         = '0;
        r         = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_p", 64'(p), 64'd0);
        check_val("rst_bad", 64'(bad_rem), 64'd0);

        // Directed cases.
        run_txn(16'd1234, 16'd56, 16'd7, 0, 1'b0);
        check_val("dir1_value", 64'(ref_p(16'd1234, 16'd56, 16'd7)), 64'd69111);
        run_txn(16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 1'b0);
        run_txn(16'd3, 16'd5, 16'd5, 0, 1'b0);
        run_txn(16'd100, 16'd0, 16'd9, 0, 1'b0);
        run_txn(16'd0, 16'd77, 16'd3, 2, 1'b0);
        run_txn(16'd321, 16'd999, 16'd12, 10, 1'b0);
        run_txn(16'd4321, 16'd17, 16'd16, 1, 1'b1);

        // Reset five cycles into MUL: result must be discarded.
        @(negedge clk);
        in_valid = 1'b1;
        q = 16'd500; b = 16'd600; r = 16'd700;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("abort_in_ready", 64'(in_ready), 64'd1);
        check_val("abort_out_valid", 64'(out_valid), 64'd0);
        check_val("abort_p", 64'(p), 64'd0);
        check_val("abort_bad", 64'(bad_rem), 64'd0);
        never = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) never = 1'b0;
        end
        check_val("abort_no_valid", 64'(never), 64'd1);
        run_txn(16'd2000, 16'd30, 16'd29, 0, 1'b0);

        // Randomized triples with occasional corner operands.
        for (int n = 0; n < 1000; n++) begin
            logic [W-1:0] rq, rb, rr;
            rq = W'($urandom);
            rb = W'($urandom);
            rr = W'($urandom);
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rq = '0;
                2: rr = W'($urandom_range(0, 255)) % ((rb == 0) ? W'(1) : rb);
                3: begin rq = '1; rb = '1; end
                default: ;
            endcase
            run_txn(rq, rb, rr, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
